// File: rtl/retry_pkg.sv
// Shared encodings, header layout and output payload for the receive-side flit unpacker.
package retry_pkg;

    localparam int unsigned PAYLOAD_W = 512;
    localparam int unsigned CRC_W     = 16;
    localparam int unsigned FLIT_W    = PAYLOAD_W + CRC_W;
    localparam int unsigned LLCTRL_W  = 4;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned RNUM_W    = 5;
    localparam int unsigned RUN_W     = 3;

    // Header field offsets inside the payload
    localparam int unsigned HDR_TYPE_BIT   = 0;
    localparam int unsigned HDR_EMPTY_BIT  = 1;
    localparam int unsigned HDR_ACK_BIT    = 2;
    localparam int unsigned HDR_LLCTRL_LSB = 4;
    localparam int unsigned HDR_SUB_LSB    = 8;
    localparam int unsigned HDR_BYTE_LSB   = 12;
    localparam int unsigned HDR_RNUM_LSB   = 20;
    localparam int unsigned HDR_RUN_LSB    = 25;

    // Polynomial 0x1F053 with the implicit x^16 term dropped
    localparam logic [CRC_W-1:0] CRC_POLY = 16'hF053;

    typedef enum logic [LLCTRL_W-1:0] {
        LLCTRL_RETRY = 4'b0011
    } llctrl_type_e;

    typedef enum logic [LLCTRL_W-1:0] {
        SUB_IDLE = 4'b0000,
        SUB_REQ  = 4'b0001,
        SUB_ACK  = 4'b0010
    } llctrl_sub_e;

    typedef struct packed {
        logic                valid_sig;
        logic                valid_crc;
        logic                flit_type;
        logic                all_data;
        logic                empty;
        logic [LLCTRL_W-1:0] llctrl;
        logic [LLCTRL_W-1:0] subtype;
        logic                req_seq;
        logic                ack_seq;
        logic [BYTE_W-1:0]   full_ack;
        logic [BYTE_W-1:0]   rdptr_eseq;
        logic [RNUM_W-1:0]   retry_num;
    } unpk_out_t;

endpackage

// File: rtl/crc16_check.sv
// Combinational CRC-16 over a 512-bit payload, processed MSB-first.
module crc16_check
    import retry_pkg::*;
#(
    parameter logic [CRC_W-1:0] CRC_INIT = 16'h0000
) (
    input  logic [PAYLOAD_W-1:0] payload,
    output logic [CRC_W-1:0]     crc_c
);

    logic [CRC_W-1:0] crc_v;
    logic             fb;

    always_comb begin
        crc_v = CRC_INIT;
        fb    = 1'b0;
        for (int i = int'(PAYLOAD_W) - 1; i >= 0; i--) begin
            fb    = crc_v[CRC_W-1] ^ payload[i];
            crc_v = {crc_v[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : {CRC_W{1'b0}});
        end
        crc_c = crc_v;
    end

endmodule

// File: rtl/llctrl_flit_unpacker.sv
// Receive-side flit decoder: CRC check, all-data run tracking and LLCTRL header decode.
module llctrl_flit_unpacker
    import retry_pkg::*;
#(
    parameter logic [CRC_W-1:0] CRC_INIT     = 16'h0000,
    parameter int unsigned      MAX_DATA_RUN = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flit_valid,
    input  logic [527:0]      i_flit,
    input  logic              discard_received_flits,
    output logic              unpacker_valid_sig,
    output logic              unpacker_valid_crc,
    output logic              unpacker_flit_type,
    output logic              unpacker_all_data_flit_flag,
    output logic              unpacker_empty_bit,
    output logic [3:0]        unpacker_llctrl,
    output logic [3:0]        unpacker_llctrl_subtype,
    output logic              unpacker_req_seq_flag,
    output logic              unpacker_ack_seq_flag,
    output logic [7:0]        unpacker_full_ack,
    output logic [7:0]        unpacker_rdptr_eseq_num,
    output logic [4:0]        unpacker_retryreq_num
);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

    logic [PAYLOAD_W-1:0] payload;
    logic [CRC_W-1:0]     crc_rx;
    logic [CRC_W-1:0]     crc_calc_c;
    logic                 crc_ok_c;

    logic                 hdr_type;
    logic                 hdr_empty;
    logic                 hdr_ack;
    logic [LLCTRL_W-1:0]  hdr_llctrl;
    logic [LLCTRL_W-1:0]  hdr_sub;
    logic [BYTE_W-1:0]    hdr_byte;
    logic [RNUM_W-1:0]    hdr_rnum;
    logic [RUN_W-1:0]     hdr_run;
    logic [RUN_W-1:0]     run_sat_c;

    unpk_out_t            out_d, out_q;
    logic [RUN_W-1:0]     run_cnt_d, run_cnt_q;

    assign payload = i_flit[PAYLOAD_W-1:0];
    assign crc_rx  = i_flit[FLIT_W-1:PAYLOAD_W];

    crc16_check #(
        .CRC_INIT (CRC_INIT)
    ) u_crc (
        .payload (payload),
        .crc_c   (crc_calc_c)
    );

    assign crc_ok_c = (crc_calc_c == crc_rx);

    // Header field extraction; only meaningful outside a data run
    assign hdr_type   = payload[HDR_TYPE_BIT];
    assign hdr_empty  = payload[HDR_EMPTY_BIT];
    assign hdr_ack    = payload[HDR_ACK_BIT];
    assign hdr_llctrl = payload[HDR_LLCTRL_LSB +: LLCTRL_W];
    assign hdr_sub    = payload[HDR_SUB_LSB +: LLCTRL_W];
    assign hdr_byte   = payload[HDR_BYTE_LSB +: BYTE_W];
    assign hdr_rnum   = payload[HDR_RNUM_LSB +: RNUM_W];
    assign hdr_run    = payload[HDR_RUN_LSB +: RUN_W];
    assign run_sat_c  = (hdr_run > RUN_MAX) ? RUN_MAX : hdr_run;

    // Next-state decode: pulses default low, fields hold, run counter holds
    always_comb begin
        out_d           = out_q;
        out_d.valid_sig = 1'b0;
        out_d.valid_crc = 1'b0;
        out_d.req_seq   = 1'b0;
        out_d.ack_seq   = 1'b0;
        run_cnt_d       = run_cnt_q;

        if (i_flit_valid) begin
            if (!crc_ok_c) begin
                // Sender will replay, so the announced run is abandoned
                out_d     = '0;
                run_cnt_d = '0;
            end else begin
                out_d.valid_crc = 1'b1;
                if (run_cnt_q != '0) begin
                    out_d.valid_sig = ~discard_received_flits;
                    out_d.flit_type = 1'b0;
                    out_d.all_data  = 1'b1;
                    run_cnt_d       = run_cnt_q - RUN_W'(1);
                end else if (hdr_type) begin
                    out_d.valid_sig = 1'b1;
                    out_d.flit_type = 1'b1;
                    out_d.all_data  = 1'b0;
                    out_d.empty     = hdr_empty;
                    out_d.llctrl    = hdr_llctrl;
                    out_d.subtype   = hdr_sub;
                    if (hdr_llctrl == LLCTRL_RETRY && hdr_sub == SUB_REQ) begin
                        out_d.req_seq    = 1'b1;
                        out_d.rdptr_eseq = hdr_byte;
                        out_d.retry_num  = hdr_rnum;
                    end else if (hdr_llctrl == LLCTRL_RETRY && hdr_sub == SUB_ACK) begin
                        out_d.ack_seq   = 1'b1;
                        out_d.full_ack  = hdr_byte;
                        out_d.retry_num = hdr_rnum;
                    end
                end else begin
                    out_d.valid_sig = ~discard_received_flits;
                    out_d.flit_type = 1'b0;
                    out_d.all_data  = 1'b0;
                    out_d.empty     = hdr_empty;
                    if (hdr_ack) begin
                        out_d.full_ack = hdr_byte;
                    end
                    run_cnt_d = run_sat_c;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q     <= '0;
            run_cnt_q <= '0;
        end else begin
            out_q     <= out_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    assign unpacker_valid_sig          = out_q.valid_sig;
    assign unpacker_valid_crc          = out_q.valid_crc;
    assign unpacker_flit_type          = out_q.flit_type;
    assign unpacker_all_data_flit_flag = out_q.all_data;
    assign unpacker_empty_bit          = out_q.empty;
    assign unpacker_llctrl             = out_q.llctrl;
    assign unpacker_llctrl_subtype     = out_q.subtype;
    assign unpacker_req_seq_flag       = out_q.req_seq;
    assign unpacker_ack_seq_flag       = out_q.ack_seq;
    assign unpacker_full_ack           = out_q.full_ack;
    assign unpacker_rdptr_eseq_num     = out_q.rdptr_eseq;
    assign unpacker_retryreq_num       = out_q.retry_num;

endmodule

// File: tb/tb_llctrl_flit_unpacker.sv
// Directed self-checking bench for llctrl_flit_unpacker.
module tb_llctrl_flit_unpacker;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_flit_valid;
    logic [527:0] i_flit;
    logic         discard_received_flits;
    logic         unpacker_valid_sig;
    logic         unpacker_valid_crc;
    logic         unpacker_flit_type;
    logic         unpacker_all_data_flit_flag;
    logic         unpacker_empty_bit;
    logic [3:0]   unpacker_llctrl;
    logic [3:0]   unpacker_llctrl_subtype;
    logic         unpacker_req_seq_flag;
    logic         unpacker_ack_seq_flag;
    logic [7:0]   unpacker_full_ack;
    logic [7:0]   unpacker_rdptr_eseq_num;
    logic [4:0]   unpacker_retryreq_num;
    logic [35:0]  all_out;

    int checks   = 0;
    int failures = 0;

    llctrl_flit_unpacker dut (
        .i_clk                       (i_clk),
        .i_rst_n                     (i_rst_n),
        .i_flit_valid                (i_flit_valid),
        .i_flit                      (i_flit),
        .discard_received_flits      (discard_received_flits),
        .unpacker_valid_sig          (unpacker_valid_sig),
        .unpacker_valid_crc          (unpacker_valid_crc),
        .unpacker_flit_type          (unpacker_flit_type),
        .unpacker_all_data_flit_flag (unpacker_all_data_flit_flag),
        .unpacker_empty_bit          (unpacker_empty_bit),
        .unpacker_llctrl             (unpacker_llctrl),
        .unpacker_llctrl_subtype     (unpacker_llctrl_subtype),
        .unpacker_req_seq_flag       (unpacker_req_seq_flag),
        .unpacker_ack_seq_flag       (unpacker_ack_seq_flag),
        .unpacker_full_ack           (unpacker_full_ack),
        .unpacker_rdptr_eseq_num     (unpacker_rdptr_eseq_num),
        .unpacker_retryreq_num       (unpacker_retryreq_num)
    );

    assign all_out = {unpacker_valid_sig, unpacker_valid_crc, unpacker_flit_type,
                      unpacker_all_data_flit_flag, unpacker_empty_bit, unpacker_llctrl,
                      unpacker_llctrl_subtype, unpacker_req_seq_flag, unpacker_ack_seq_flag,
                      unpacker_full_ack, unpacker_rdptr_eseq_num, unpacker_retryreq_num};

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Reference CRC-16, poly 0x1F053, seed 0, MSB-first
    function automatic logic [15:0] ref_crc(input logic [511:0] d);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        for (int i = 511; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'hF053;
        end
        return c;
    endfunction

    function automatic logic [511:0] hdr(input logic typ, input logic emp, input logic ack,
                                         input logic [3:0] ll, input logic [3:0] sub,
                                         input logic [7:0] byt, input logic [4:0] rn,
                                         input logic [2:0] run);
        logic [511:0] p;
        p         = {{15{32'hA5C3_1E07}}, 32'h0};
        p[0]      = typ;
        p[1]      = emp;
        p[2]      = ack;
        p[7:4]    = ll;
        p[11:8]   = sub;
        p[19:12]  = byt;
        p[24:20]  = rn;
        p[27:25]  = run;
        return p;
    endfunction

    function automatic logic [527:0] mk(input logic [511:0] p);
        return {ref_crc(p), p};
    endfunction

    task automatic send(input logic [527:0] f, input logic disc);
        @(negedge i_clk);
        i_flit                 = f;
        i_flit_valid           = 1'b1;
        discard_received_flits = disc;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        @(negedge i_clk);
        i_flit_valid           = 1'b0;
        discard_received_flits = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_flit_valid = 1'b0;
        i_flit = '0;
        discard_received_flits = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (all_out !== 36'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", all_out);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_protocol_run();
        send(mk(hdr(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 8'h05, 5'h0, 3'd2)), 1'b0);
        checks++;
        if ({unpacker_valid_sig, unpacker_valid_crc, unpacker_all_data_flit_flag, unpacker_full_ack} !== {3'b110, 8'h05}) begin
            failures++;
            $display("FAIL proto_hdr got=%b/%b/%b ack=%h exp=1/1/0 ack=05", unpacker_valid_sig,
                     unpacker_valid_crc, unpacker_all_data_flit_flag, unpacker_full_ack);
        end
        // Data flits look like RETRY.REQ headers; they must not be decoded
        for (int k = 0; k < 2; k++) begin
            send(mk(hdr(1'b1, 1'b0, 1'b0, 4'h3, 4'h1, 8'hEE, 5'h1F, 3'd7)), 1'b0);
            checks++;
            if ({unpacker_all_data_flit_flag, unpacker_flit_type, unpacker_req_seq_flag, unpacker_valid_sig} !== 4'b1001) begin
                failures++;
                $display("FAIL data_flit%0d got=%b%b%b%b exp=1001", k, unpacker_all_data_flit_flag,
                         unpacker_flit_type, unpacker_req_seq_flag, unpacker_valid_sig);
            end
        end
        send(mk(hdr(1'b1, 1'b0, 1'b0, 4'h1, 4'h0, 8'h00, 5'h0, 3'd0)), 1'b0);
        checks++;
        if ({unpacker_flit_type, unpacker_all_data_flit_flag, unpacker_llctrl, unpacker_req_seq_flag} !== {2'b10, 4'h1, 1'b0}) begin
            failures++;
            $display("FAIL hdr_resume got=%b%b ll=%h req=%b exp=10 ll=1 req=0", unpacker_flit_type,
                     unpacker_all_data_flit_flag, unpacker_llctrl, unpacker_req_seq_flag);
        end
        idle();
    endtask

    task automatic test_retry_req();
        send(mk(hdr(1'b1, 1'b0, 1'b0, 4'h3, 4'h1, 8'h3C, 5'd3, 3'd0)), 1'b0);
        checks++;
        if ({unpacker_req_seq_flag, unpacker_ack_seq_flag, unpacker_rdptr_eseq_num, unpacker_retryreq_num} !== {2'b10, 8'h3C, 5'd3}) begin
            failures++;
            $display("FAIL retry_req got=%b%b eseq=%h num=%0d exp=10 eseq=3c num=3", unpacker_req_seq_flag,
                     unpacker_ack_seq_flag, unpacker_rdptr_eseq_num, unpacker_retryreq_num);
        end
        checks++;
        if ({unpacker_llctrl, unpacker_llctrl_subtype, unpacker_flit_type, unpacker_valid_sig} !== {4'h3, 4'h1, 2'b11}) begin
            failures++;
            $display("FAIL retry_req_type got=%h/%h/%b%b exp=3/1/11", unpacker_llctrl,
                     unpacker_llctrl_subtype, unpacker_flit_type, unpacker_valid_sig);
        end
        idle();
        checks++;
        if ({unpacker_req_seq_flag, unpacker_valid_sig, unpacker_rdptr_eseq_num} !== {2'b00, 8'h3C}) begin
            failures++;
            $display("FAIL req_pulse_hold got=%b%b eseq=%h exp=00 eseq=3c", unpacker_req_seq_flag,
                     unpacker_valid_sig, unpacker_rdptr_eseq_num);
        end
    endtask

    task automatic test_crc_error();
        logic [527:0] f;
        f = mk(hdr(1'b1, 1'b0, 1'b0, 4'h3, 4'h2, 8'h55, 5'd2, 3'd0));
        f[0] = ~f[0];
        send(f, 1'b0);
        checks++;
        if (all_out !== 36'h0) begin
            failures++;
            $display("FAIL crc_err_zero got=%h exp=0", all_out);
        end
        idle();
    endtask

    task automatic test_crc_in_run();
        logic [527:0] f;
        send(mk(hdr(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 5'h0, 3'd3)), 1'b0);
        f = mk(hdr(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'h12, 5'h0, 3'd0));
        f[300] = ~f[300];
        send(f, 1'b0);
        checks++;
        if ({unpacker_valid_crc, unpacker_all_data_flit_flag, unpacker_valid_sig} !== 3'b000) begin
            failures++;
            $display("FAIL run_crc_err got=%b%b%b exp=000", unpacker_valid_crc,
                     unpacker_all_data_flit_flag, unpacker_valid_sig);
        end
        send(mk(hdr(1'b1, 1'b0, 1'b0, 4'h3, 4'h2, 8'h9A, 5'd5, 3'd0)), 1'b0);
        checks++;
        if ({unpacker_ack_seq_flag, unpacker_flit_type, unpacker_all_data_flit_flag, unpacker_full_ack, unpacker_retryreq_num} !== {3'b110, 8'h9A, 5'd5}) begin
            failures++;
            $display("FAIL ack_after_err got=%b%b%b ack=%h num=%0d exp=110 ack=9a num=5", unpacker_ack_seq_flag,
                     unpacker_flit_type, unpacker_all_data_flit_flag, unpacker_full_ack, unpacker_retryreq_num);
        end
        idle();
    endtask

    task automatic test_discard();
        send(mk(hdr(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 8'h11, 5'h0, 3'd1)), 1'b1);
        checks++;
        if ({unpacker_valid_sig, unpacker_valid_crc} !== 2'b01) begin
            failures++;
            $display("FAIL discard_proto got=%b%b exp=01", unpacker_valid_sig, unpacker_valid_crc);
        end
        send(mk(hdr(1'b1, 1'b0, 1'b0, 4'h3, 4'h1, 8'hAB, 5'd1, 3'd0)), 1'b1);
        checks++;
        if ({unpacker_all_data_flit_flag, unpacker_valid_sig, unpacker_req_seq_flag} !== 3'b100) begin
            failures++;
            $display("FAIL discard_data got=%b%b%b exp=100", unpacker_all_data_flit_flag,
                     unpacker_valid_sig, unpacker_req_seq_flag);
        end
        send(mk(hdr(1'b1, 1'b0, 1'b0, 4'h3, 4'h1, 8'h42, 5'd7, 3'd0)), 1'b1);
        checks++;
        if ({unpacker_req_seq_flag, unpacker_valid_sig, unpacker_rdptr_eseq_num, unpacker_retryreq_num} !== {2'b11, 8'h42, 5'd7}) begin
            failures++;
            $display("FAIL discard_req got=%b%b eseq=%h num=%0d exp=11 eseq=42 num=7", unpacker_req_seq_flag,
                     unpacker_valid_sig, unpacker_rdptr_eseq_num, unpacker_retryreq_num);
        end
        idle();
    endtask

    task automatic test_saturation();
        send(mk(hdr(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 5'h0, 3'd7)), 1'b0);
        checks++;
        if ({unpacker_empty_bit, unpacker_valid_sig} !== 2'b11) begin
            failures++;
            $display("FAIL sat_hdr got=%b%b exp=11", unpacker_empty_bit, unpacker_valid_sig);
        end
        for (int k = 0; k < 4; k++) begin
            send(mk(hdr(1'b1, 1'b0, 1'b0, 4'h3, 4'h1, 8'h77, 5'd9, 3'd0)), 1'b0);
            checks++;
            if ({unpacker_all_data_flit_flag, unpacker_req_seq_flag} !== 2'b10) begin
                failures++;
                $display("FAIL sat_data%0d got=%b%b exp=10", k, unpacker_all_data_flit_flag, unpacker_req_seq_flag);
            end
        end
        send(mk(hdr(1'b1, 1'b0, 1'b0, 4'h3, 4'h1, 8'h01, 5'd0, 3'd0)), 1'b0);
        checks++;
        if ({unpacker_all_data_flit_flag, unpacker_req_seq_flag, unpacker_rdptr_eseq_num} !== {2'b01, 8'h01}) begin
            failures++;
            $display("FAIL sat_end got=%b%b eseq=%h exp=01 eseq=01", unpacker_all_data_flit_flag,
                     unpacker_req_seq_flag, unpacker_rdptr_eseq_num);
        end
        idle();
    endtask

    task automatic test_invalid_hold();
        send(mk(hdr(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 8'h2B, 5'h0, 3'd1)), 1'b0);
        idle();
        checks++;
        if ({unpacker_valid_sig, unpacker_valid_crc, unpacker_full_ack} !== {2'b00, 8'h2B}) begin
            failures++;
            $display("FAIL invalid_hold got=%b%b ack=%h exp=00 ack=2b", unpacker_valid_sig,
                     unpacker_valid_crc, unpacker_full_ack);
        end
        send(mk(hdr(1'b1, 1'b0, 1'b0, 4'h3, 4'h2, 8'h66, 5'd4, 3'd0)), 1'b0);
        checks++;
        if ({unpacker_all_data_flit_flag, unpacker_ack_seq_flag, unpacker_full_ack} !== {2'b10, 8'h2B}) begin
            failures++;
            $display("FAIL run_kept got=%b%b ack=%h exp=10 ack=2b", unpacker_all_data_flit_flag,
                     unpacker_ack_seq_flag, unpacker_full_ack);
        end
        idle();
    endtask

    task automatic test_reset_midrun();
        send(mk(hdr(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 8'h77, 5'h0, 3'd3)), 1'b0);
        send(mk(hdr(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 5'h0, 3'd0)), 1'b0);
        @(negedge i_clk);
        i_flit_valid = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== 36'h0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0", all_out);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        send(mk(hdr(1'b1, 1'b0, 1'b0, 4'h3, 4'h1, 8'h3C, 5'd3, 3'd0)), 1'b0);
        checks++;
        if ({unpacker_req_seq_flag, unpacker_all_data_flit_flag, unpacker_rdptr_eseq_num} !== {2'b10, 8'h3C}) begin
            failures++;
            $display("FAIL post_reset_hdr got=%b%b eseq=%h exp=10 eseq=3c", unpacker_req_seq_flag,
                     unpacker_all_data_flit_flag, unpacker_rdptr_eseq_num);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_protocol_run();
        test_retry_req();
        test_crc_error();
        test_crc_in_run();
        test_discard();
        test_saturation();
        test_invalid_hold();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/llctrl_flit_unpacker.md
# llctrl_flit_unpacker

Receive-side flit decoder placed directly upstream of the retry block. It takes each 528-bit flit from the physical-layer interface and checks the CRC. It tracks all-data flit runs, decodes the link-layer control (LLCTRL) header, and drives the registered `unpacker_*` strobes and fields that the retry state machines, ESeq tracking and acknowledge logic consume.

## Interface
- `CRC_INIT`, 16'h0000: CRC-16 seed.
- `MAX_DATA_RUN`, 4: maximum all-data flits announced by one protocol flit.
- `i_clk` in 1: clock.
- `i_rst_n` in 1: asynchronous active-low reset. One clock, reset asynchronous and active-low.
- `i_flit_valid` in 1: a flit is present this cycle.
- `i_flit` in 528: [511:0] payload, [527:512] CRC.
- `discard_received_flits` in 1: suppress non-LLCTRL flits (retry in progress).
- `unpacker_valid_sig` out 1: decoded flit accepted, 1-cycle pulse.
- `unpacker_valid_crc` out 1: CRC matched for the flit presented last cycle.
- `unpacker_flit_type` out 1: 0 = protocol, 1 = LLCTRL.
- `unpacker_all_data_flit_flag` out 1: current flit is an all-data flit.
- `unpacker_empty_bit` out 1: header empty bit.
- `unpacker_llctrl` out 4: LLCTRL type.
- `unpacker_llctrl_subtype` out 4: LLCTRL subtype.
- `unpacker_req_seq_flag` out 1: RETRY.REQ received.
- `unpacker_ack_seq_flag` out 1: RETRY.ACK received.
- `unpacker_full_ack` out 8: acknowledge count / RETRY.ACK payload.
- `unpacker_rdptr_eseq_num` out 8: ESeq carried by RETRY.REQ.
- `unpacker_retryreq_num` out 5: NUM_RETRY field of RETRY.REQ/ACK.

## Operation

**Header fields** (payload bits):
- [0] type
- [1] empty
- [2] ack
- [7:4] llctrl
- [11:8] subtype
- [19:12] byte field
- [24:20] retry num
- [27:25] data-run count (protocol flits only)

**CRC**
- CRC-16, polynomial 0x1F053, seed `CRC_INIT`.
- Computed MSB-first over payload bits 511 down to 0.
- Compared with [527:512]. Mismatch means `unpacker_valid_crc`=0, and all flags and fields are held at 0 for that cycle.

**Data-run counter** `run_cnt` (3 bit):
- A good-CRC protocol flit loads `run_cnt` from [27:25], saturated to `MAX_DATA_RUN`.
- While `run_cnt`≠0, every valid flit is an all-data flit:
  - No header decode; `unpacker_all_data_flit_flag`=1, `unpacker_flit_type`=0.
  - `run_cnt` decrements by 1.
  - CRC is still checked.
- A CRC error at any point clears `run_cnt` to 0, because the sender will replay.

**LLCTRL decode** (good CRC, not in a data run, type=1):
- `unpacker_llctrl`/`unpacker_llctrl_subtype` = fields.
- llctrl=4'b0011, subtype=4'b0001 (RETRY.REQ):
  - `unpacker_req_seq_flag`=1.
  - `unpacker_rdptr_eseq_num` = byte field.
  - `unpacker_retryreq_num` = retry num.
- llctrl=4'b0011, subtype=4'b0010 (RETRY.ACK):
  - `unpacker_ack_seq_flag`=1.
  - `unpacker_full_ack` = byte field.
  - `unpacker_retryreq_num` = retry num.
- Any other LLCTRL: fields passed, no seq flags.

**Protocol flit decode:**
- When ack=1, `unpacker_full_ack` = byte field.
- `unpacker_empty_bit` = [1].

**Discard:**
- While `discard_received_flits`=1, protocol and all-data flits give `unpacker_valid_sig`=0.
- `run_cnt` still tracks the data run so alignment is kept.
- LLCTRL flits still decode normally.

**Invalid cycles:** `i_flit_valid`=0 drives all pulse outputs to 0 next cycle. Field outputs hold their last value; `run_cnt` is unchanged.

## Timing
- Latency is 1 cycle: flit at edge N gives outputs valid after edge N+1.
- All outputs are registered.
- `unpacker_valid_sig`, `unpacker_valid_crc`, `unpacker_req_seq_flag` and `unpacker_ack_seq_flag` are single-cycle pulses per flit.
- Back-to-back flits are accepted every cycle; there is no backpressure.
- Reset:
  - All outputs go to 0 and `run_cnt` goes to 0 immediately on `i_rst_n` falling.
  - The first flit after deassertion is treated as a header flit.
- `discard_received_flits` is sampled in the same cycle as `i_flit_valid`.
- Reset mid-run abandons the run without any output pulse.

## Structure
- Package `retry_pkg`:
  - LLCTRL type/subtype encodings (LLCTRL_RETRY, SUB_REQ, SUB_ACK, SUB_IDLE).
  - Header field bit offsets.
  - CRC polynomial constant.
- Sub-module `crc16_check`: purely combinational, 512-bit payload in, 16-bit CRC out. It is instantiated once and shared nowhere else.
- The top level holds the input-side decode, `run_cnt` and the output register stage.

## Test plan
- Protocol flit, good CRC, ack=1, byte=8'h05, run=2, followed by 2 flits: out valid_sig=1, full_ack=5, then 2 cycles of all_data_flit_flag=1, then header decode resumes.
- RETRY.REQ, byte=8'h3C, retry num=3, good CRC: req_seq_flag=1, rdptr_eseq_num=8'h3C, retryreq_num=3, one cycle after input.
- RETRY.ACK with one CRC bit flipped: valid_crc=0, ack_seq_flag=0, all fields 0.
- CRC error in the 1st of 3 announced data flits, then a RETRY.ACK: run cleared, and the next flit decodes as a header (ack_seq_flag=1).
- discard=1, then a protocol flit and a RETRY.REQ: protocol flit gives valid_sig=0; RETRY.REQ gives req_seq_flag=1.
- `i_rst_n` asserted with run_cnt=2: outputs 0 asynchronously; after release, the first flit decodes as a header.
